// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge
// Turns an instruction-cache read request into one AXI4 read burst. A cached
// request becomes a full-line INCR burst and an uncached request becomes a
// single beat. The beats are assembled in a line buffer, and the result is
// returned with a one-cycle ret_valid pulse.
//
// Ports
//   clk_g, reset                 clock, asynchronous active-high reset
//   rd_req/rd_uncache/rd_addr    cache request (held until rd_rdy)
//   rd_rdy                       combinational accept strobe
//   ret_valid/ret_data/bus_err   returned line, error qualified by ret_valid
//   ar*                          AXI4 read-address channel
//   r*                           AXI4 read-data channel (rid ignored)
//
// Build option
//   ICACHE_AXI_RRESP_CHECK_EN    when defined, a non-OKAY rresp on any beat
//                                sets bus_err for the returned line. When
//                                undefined, bus_err is tied low.

module icache_axi_rd_bridge #(
  parameter logic [3:0]  AXI_ID     = 4'd0,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic         clk_g,
  input  logic         reset,
  input  logic         rd_req,
  input  logic         rd_uncache,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  output logic         bus_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam int unsigned CNT_W    = $clog2(LINE_BEATS + 1);
  localparam logic [7:0]  LEN_LINE = 8'(LINE_BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             accept;
  logic             beat;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_flag;
  logic             err_nx;

  // Gate rd_rdy with reset: the reset state is IDLE, but no request may be
  // accepted while reset is held.
  assign rd_rdy  = !reset && (state == IDLE) && rd_req;

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Next-state logic. rlast alone ends the burst, and the beat count is
  // never used to decide completion.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    beat     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          accept   = 1'b1;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        if (arready) state_nx = DATA;
      end
      DATA: begin
        if (rvalid) begin
          beat = 1'b1;
          if (rlast) state_nx = RET;
        end
      end
      RET:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ICACHE_AXI_RRESP_CHECK_EN
  // Sticky error: cleared on accept, set by any non-OKAY beat.
  assign err_nx = accept ? 1'b0 : (err_flag | (beat && (rresp != 2'b00)));
`else
  assign err_nx = 1'b0;
`endif

  // State, handshake outputs and datapath. The handshake outputs are
  // registered copies of the next-state decode.
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      ret_valid <= 1'b0;
      bus_err   <= 1'b0;
      err_flag  <= 1'b0;
      ret_data  <= '0;
      araddr    <= '0;
      arlen     <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nx;
      arvalid   <= (state_nx == ADDR);
      rready    <= (state_nx == DATA);
      ret_valid <= (state_nx == RET);
      err_flag  <= err_nx;
      bus_err   <= (state_nx == RET) && err_nx;
      if (accept) begin
        araddr   <= rd_addr;
        arlen    <= rd_uncache ? 8'd0 : LEN_LINE;
        beat_cnt <= '0;
      end
      if (beat) begin
        ret_data <= {rdata, ret_data[127:32]};
        if (beat_cnt != CNT_W'(LINE_BEATS)) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // The beat counter is kept for observability only. rid is not used by
  // the bridge, and rresp and err_flag are dead when error checking is
  // compiled out.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, err_flag, beat_cnt};

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb_icache_axi_rd_bridge
// Directed, table-driven bench for icache_axi_rd_bridge. Each table row is one
// read transaction with hand-computed expectations for the AR payload, the
// returned line, bus_err and latency. Hand-written sequences cover reset
// values, reset mid-burst and stray R beats. A free-running monitor checks
// that arvalid, rready and ret_valid are mutually exclusive, and it counts
// ret_valid pulses.

module tb_icache_axi_rd_bridge;

`ifdef ICACHE_AXI_RRESP_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk_g = 1'b0;
  logic         reset;
  logic         rd_req, rd_uncache;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, bus_err;
  logic [127:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  icache_axi_rd_bridge dut (
    .clk_g(clk_g), .reset(reset), .rd_req(rd_req), .rd_uncache(rd_uncache),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_data(ret_data), .bus_err(bus_err), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_g = ~clk_g;

  typedef struct packed {
    logic            unc;
    logic [31:0]     addr;
    logic [2:0]      nb;
    logic [3:0][31:0] d;
    logic [3:0][1:0] rr;
    logic [7:0]      ard;
    logic [7:0]      gap;
    logic            hold;
    logic [7:0]      xlen;
    logic [127:0]    xdata;
    logic            xerr;
    logic [7:0]      xlat;
  } vec_t;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  pulses = 0;
  int unsigned  cyc = 0;
  int           cur = -1;
  logic [127:0] prev;
  vec_t         vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [v%0d] %s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic unc, input logic [31:0] addr, input logic [2:0] nb,
                              input logic [127:0] d, input logic [7:0] rr, input logic [7:0] ard,
                              input logic [7:0] gap, input logic hold, input logic [7:0] xlen,
                              input logic [127:0] xdata, input logic xerr, input logic [7:0] xlat);
    vec_t v;
    v.unc = unc; v.addr = addr; v.nb = nb; v.d = d; v.rr = rr; v.ard = ard;
    v.gap = gap; v.hold = hold; v.xlen = xlen; v.xdata = xdata; v.xerr = xerr;
    v.xlat = xlat;
    return v;
  endfunction

  always @(posedge clk_g) cyc++;

  // Handshake exclusivity and ret_valid pulse counting.
  always @(negedge clk_g) begin
    if (!reset) begin
      checks++;
      if ((arvalid && rready) || ((arvalid || rready) && ret_valid)) begin
        errors++;
        $display("FAIL excl: got arvalid=%0b rready=%0b ret_valid=%0b expected at most one high",
                 arvalid, rready, ret_valid);
      end
      if (ret_valid) pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // One read transaction. It starts at the negedge of an IDLE cycle and
  // ends at the negedge of the RET cycle.
  task automatic run_txn(input vec_t v);
    int unsigned c0;
    @(negedge clk_g);
    chk("ret_valid_low_idle", ret_valid, 1'b0);
    rd_req = 1'b1; rd_uncache = v.unc; rd_addr = v.addr;
    #1;
    chk("rd_rdy_idle", rd_rdy, 1'b1);
    c0 = cyc;
    @(negedge clk_g);
    if (!v.hold) rd_req = 1'b0;
    chk("rd_rdy_addr", rd_rdy, 1'b0);
    chk("arvalid", arvalid, 1'b1);
    chk("rready_addr", rready, 1'b0);
    chk("araddr", araddr, v.addr);
    chk("arlen", arlen, v.xlen);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd0);
    chk("ret_data_hold", ret_data, prev);
    for (int k = 0; k < int'(v.ard); k++) begin
      // A stray R beat while still in ADDR must be ignored.
      rvalid = 1'b1; rdata = 32'hBAD0_0000; rlast = 1'b1;
      #1;
      chk("rready_stray", rready, 1'b0);
      @(negedge clk_g);
      chk("araddr_stable", araddr, v.addr);
      chk("arlen_stable", arlen, v.xlen);
      chk("arvalid_stable", arvalid, 1'b1);
    end
    rvalid = 1'b0; rlast = 1'b0;
    arready = 1'b1;
    @(negedge clk_g);
    arready = 1'b0;
    for (int i = 0; i < int'(v.nb); i++) begin
      if (i > 0) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          chk("rready_gap", rready, 1'b1);
          @(negedge clk_g);
        end
      end
      rvalid = 1'b1; rdata = v.d[i]; rresp = v.rr[i]; rlast = (i == int'(v.nb) - 1);
      chk("rready_beat", rready, 1'b1);
      chk("ret_valid_beat", ret_valid, 1'b0);
      chk("rd_rdy_data", rd_rdy, 1'b0);
      @(negedge clk_g);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    chk("ret_valid", ret_valid, 1'b1);
    chk("ret_data", ret_data, v.xdata);
    chk("bus_err", bus_err, v.xerr & CHK);
    chk("rd_rdy_ret", rd_rdy, 1'b0);
    chk("latency", 128'(cyc - c0), 128'(v.xlat));
    prev = v.xdata;
  endtask

  // Reset lands while the second beat of a cached burst is on the bus.
  task automatic reset_mid_burst();
    cur = 99;
    @(negedge clk_g);
    rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h4000_0000;
    @(negedge clk_g);
    rd_req = 1'b0; arready = 1'b1;
    @(negedge clk_g);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hF0; rlast = 1'b0;
    @(negedge clk_g);
    rdata = 32'hF1;
    chk("rready_before_rst", rready, 1'b1);
    #2 reset = 1'b1; rd_req = 1'b1;
    #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_ret_valid", ret_valid, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_ret_data", ret_data, 128'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", arlen, 8'd0);
    chk("rst_bus_err", bus_err, 1'b0);
    rd_req = 1'b0;
    @(negedge clk_g);
    #2 reset = 1'b0;
    // The abandoned burst's remaining beats keep arriving in IDLE.
    for (int i = 2; i < 4; i++) begin
      @(negedge clk_g);
      rvalid = 1'b1; rdata = 32'hF0 + 32'(i); rlast = (i == 3);
      chk("stale_rready", rready, 1'b0);
      chk("stale_ret_valid", ret_valid, 1'b0);
      chk("stale_ret_data", ret_data, 128'd0);
    end
    @(negedge clk_g);
    rvalid = 1'b0; rlast = 1'b0;
    chk("stale_ret_data_end", ret_data, 128'd0);
    chk("stale_ret_valid_end", ret_valid, 1'b0);
    prev = 128'd0;
  endtask

  initial begin
    vecs[0] = mk(1'b0, 32'h1FC0_0010, 3'd4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h00, 8'd0, 8'd0,
                 1'b0, 8'd3, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 8'd6);
    vecs[1] = mk(1'b1, 32'hBFC0_0004, 3'd1, {96'd0, 32'hDEADBEEF}, 8'h00, 8'd0, 8'd0,
                 1'b0, 8'd0, 128'hDEADBEEF_000000A3_000000A2_000000A1, 1'b0, 8'd3);
    vecs[2] = mk(1'b0, 32'h0000_1000, 3'd4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                 8'h00, 8'd5, 8'd2, 1'b0, 8'd3, 128'h44444444_33333333_22222222_11111111, 1'b0, 8'd17);
    vecs[3] = mk(1'b0, 32'h2000_0040, 3'd4, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'b00_10_00_00, 8'd0, 8'd0,
                 1'b0, 8'd3, 128'h000000B3_000000B2_000000B1_000000B0, 1'b1, 8'd6);
    vecs[4] = mk(1'b0, 32'h2000_0080, 3'd4, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'h00, 8'd0, 8'd0,
                 1'b0, 8'd3, 128'h000000C3_000000C2_000000C1_000000C0, 1'b0, 8'd6);
    vecs[5] = mk(1'b0, 32'h3000_0000, 3'd4, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 8'h00, 8'd0, 8'd0,
                 1'b1, 8'd3, 128'h000000D3_000000D2_000000D1_000000D0, 1'b0, 8'd6);
    vecs[6] = mk(1'b0, 32'h3000_0010, 3'd4, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 8'h00, 8'd0, 8'd0,
                 1'b0, 8'd3, 128'h000000E3_000000E2_000000E1_000000E0, 1'b0, 8'd6);
    vecs[7] = mk(1'b1, 32'h0000_0100, 3'd1, {96'd0, 32'h12345678}, 8'h00, 8'd0, 8'd0,
                 1'b0, 8'd0, 128'h12345678_00000000_00000000_00000000, 1'b0, 8'd3);

    reset = 1'b1; rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    prev = 128'd0;
    #1;
    chk("init_rd_rdy", rd_rdy, 1'b0);
    chk("init_arvalid", arvalid, 1'b0);
    chk("init_rready", rready, 1'b0);
    chk("init_ret_valid", ret_valid, 1'b0);
    chk("init_bus_err", bus_err, 1'b0);
    chk("init_ret_data", ret_data, 128'd0);
    chk("init_araddr", araddr, 32'd0);
    chk("init_arlen", arlen, 8'd0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk_g);
    #2 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (i == 7) reset_mid_burst();
      cur = i;
      run_txn(vecs[i]);
    end

    repeat (3) @(negedge clk_g);
    cur = -1;
    chk("ret_valid_pulses", 128'(pulses), 128'd8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
